// File: rtl/regs_access_ctrl_pkg.sv
// Shared types for the NISC register-file access controller.
// Holds the controller state encoding and the read/write opcode values.
package regs_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} regs_ctrl_state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/regs_access_ctrl_if.sv
// Request/response channel between a bus or debug initiator and regs_access_ctrl.
// The master modport is the requester; the slave modport is the controller.
interface regs_access_ctrl_if #(
    parameter int n     = 8,
    parameter int Rsize = 1
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [Rsize-1:0] req_addr;
    logic [n-1:0]     req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [n-1:0]     rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regs_access_ctrl.sv
// Initiator for the 2 x n synchronous register file: hides its one-cycle read latency.
// Define REGS_WRITE_ACK_EN to make writes return a response carrying the pre-write value.
module regs_access_ctrl
    import regs_pkg::*;
#(
    parameter int n     = 8,
    parameter int Rsize = 1
) (
    input  logic             clk,
    input  logic             nReset,
    regs_access_ctrl_if.slave bus,
    output logic             w,
    output logic [n-1:0]     Wdata,
    output logic [Rsize-1:0] Raddr,
    input  logic [n-1:0]     Rdata
);

    regs_ctrl_state_t state_q, state_d;
    logic             w_q, w_d;
    logic [n-1:0]     wdata_q, wdata_d;
    logic [Rsize-1:0] raddr_q, raddr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [n-1:0]     rsp_data_q, rsp_data_d;
    logic             req_ready;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            w_q         <= 1'b0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // In ISSUE the registered write enable doubles as the opcode of the op in flight.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    raddr_d = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    w_d     = bus.req_write;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (w_q == OP_WRITE) begin
`ifdef REGS_WRITE_ACK_EN
                    w_d     = 1'b0;
                    state_d = CAPTURE;
`else
                    req_ready = 1'b1;
                    if (bus.req_valid) begin
                        raddr_d = bus.req_addr;
                        wdata_d = bus.req_wdata;
                        w_d     = bus.req_write;
                    end else begin
                        w_d     = 1'b0;
                        state_d = IDLE;
                    end
`endif
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                w_d         = OP_READ;
                rsp_data_d  = Rdata;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                w_d         = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign w             = w_q;
    assign Wdata         = wdata_q;
    assign Raddr         = raddr_q;

endmodule
